// File: rtl/steg_pkg.sv
// steg_pkg: shared character width, terminator default and message FSM encoding for the steganography decoder
package steg_pkg;
  localparam int CHAR_W = 8;
  localparam logic [CHAR_W-1:0] TERM_DEFAULT = 8'h00;
  typedef enum logic {COLLECT = 1'b0, DONE = 1'b1} state_t;
endpackage

// File: rtl/bit_deserializer.sv
// bit_deserializer: shifts accepted LSBs into a byte and strobes on every 8th accept
module bit_deserializer
  import steg_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_accept,
  input  logic              i_bit,
  output logic [2:0]        o_cnt,
  output logic [CHAR_W-1:0] o_byte,
  output logic              o_byte_done
);
  logic [CHAR_W-1:0] r_sr;
  logic [2:0]        r_cnt;
  logic [CHAR_W-1:0] w_next;
  // o_byte is the post-shift value so the parent can capture the byte on the 8th accept edge
  assign w_next      = MSB_FIRST ? {r_sr[CHAR_W-2:0], i_bit} : {i_bit, r_sr[CHAR_W-1:1]};
  assign o_byte      = w_next;
  assign o_cnt       = r_cnt;
  assign o_byte_done = i_accept & (r_cnt == 3'd7);
  always_ff @(posedge clk) begin
    if (reset | i_clr) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_accept) begin
      r_sr  <= w_next;
      r_cnt <= r_cnt + 3'd1;
    end
  end
endmodule

// File: rtl/lsb_message_assembler.sv
// lsb_message_assembler: packs extracted LSBs into characters, emits them via valid/ready, stops on terminator or limit
module lsb_message_assembler
  import steg_pkg::*;
#(
  parameter bit                MSB_FIRST = 1'b1,
  parameter logic [CHAR_W-1:0] TERM_CHAR = TERM_DEFAULT,
  parameter int                MAX_CHARS = 256,
  localparam int               CW        = $clog2(MAX_CHARS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              bit_ready,
  output logic              char_valid,
  output logic [CHAR_W-1:0] char_out,
  input  logic              char_ready,
  output logic              msg_done,
  output logic              overflow,
  output logic [CW-1:0]     char_count
);
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_char_valid;
  logic [CHAR_W-1:0] r_char;
  logic              r_msg_done;
  logic              r_overflow;
  logic [CW-1:0]     r_count;
  logic [2:0]        w_cnt;
  logic [CHAR_W-1:0] w_byte;
  logic              w_byte_done;
  logic              w_accept;
  logic              w_hs;
  logic              w_term;
  logic              w_max;
  logic              w_load;
  assign bit_ready = (r_state == COLLECT) & ((w_cnt != 3'd7) | ~r_char_valid | char_ready);
  assign w_accept  = bit_valid & bit_ready & ~restart;
  assign w_hs      = r_char_valid & char_ready;
  assign w_term    = w_byte_done & (w_byte == TERM_CHAR);
  assign w_max     = w_hs & (r_state == COLLECT) & (r_count == CW'(MAX_CHARS - 1));
  // a byte completing on the limit-reaching handshake lies beyond the limit and is dropped
  assign w_load    = w_byte_done & ~w_term & ~w_max;
  bit_deserializer #(.MSB_FIRST(MSB_FIRST)) u_deser (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (restart),
    .i_accept   (w_accept),
    .i_bit      (bit_in),
    .o_cnt      (w_cnt),
    .o_byte     (w_byte),
    .o_byte_done(w_byte_done)
  );
  always_comb begin
    w_state_nxt = (r_state == COLLECT && (w_term || w_max)) ? DONE : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset | restart) begin
      r_state      <= COLLECT;
      r_char_valid <= 1'b0;
      r_char       <= '0;
      r_msg_done   <= 1'b0;
      r_overflow   <= 1'b0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_char_valid <= w_load | (r_char_valid & ~char_ready);
      if (w_load) r_char <= w_byte;
      if (w_hs) r_count <= r_count + 1'b1;
      r_msg_done   <= r_msg_done | w_term | w_max;
      r_overflow   <= r_overflow | w_max;
    end
  end
  assign char_valid = r_char_valid;
  assign char_out   = r_char;
  assign msg_done   = r_msg_done;
  assign overflow   = r_overflow;
  assign char_count = r_count;
endmodule
